// File: rtl/wb_line_fetch_pkg.sv
// Shared widths, FSM state encoding and a small helper for the Wishbone line fetcher.
package wb_line_fetch_pkg;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_LEN_W   = 10;
  localparam int DEF_FIFO_AW = 4;
  localparam int DEF_TMO_W   = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // True when the FIFO will have a free entry after this cycle's pop.
  function automatic logic fifo_room(input logic one_free, input logic pop);
    return one_free | pop;
  endfunction

endpackage

// File: rtl/wb_line_fetch_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous active-low reset.
module sync_fifo_fwft
  import wb_line_fetch_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = DEF_FIFO_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          one_free_o,
  output logic [AW:0]   level_o
);

  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

  logic [DW-1:0] mem_q [DEPTH_I];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_s, pop_s;

  assign full_o     = (level_q == DEPTH);
  assign empty_o    = (level_q == {(AW+1){1'b0}});
  assign one_free_o = ~full_o;
  assign level_o    = level_q;
  assign dout_o     = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign pop_s  = pop_i & ~empty_o;
  assign push_s = push_i & (~full_o | pop_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      level_d = level_q - (AW+1)'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wb_line_fetch.sv
// Wishbone read master fetching a run of bytes, one single-beat cycle per byte,
// into a FWFT FIFO drained by a valid/ready byte consumer.
module wb_line_fetch
  import wb_line_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_cyc_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  input  logic              wb_ack_i,
  input  logic [7:0]        wb_dat_i,
  output logic              rd_valid_o,
  output logic [7:0]        rd_data_o,
  input  logic              rd_ready_i
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc_s;
  logic              err_q, err_d;
  logic              busy_q, done_q, cyc_q;
  logic              push_s, pop_s, room_s, tmo_hit_s;
  logic              empty_s, full_s, one_free_s;
  logic [FIFO_AW:0]  level_s;
  logic              fifo_unused_s;

  assign pop_s         = ~empty_s & rd_ready_i;
  assign push_s        = (state_q == ST_REQ) & wb_ack_i;
  assign room_s        = fifo_room(one_free_s, pop_s);
  assign tmo_inc_s     = tmo_q + TMO_W'(1);
  assign tmo_hit_s     = &tmo_inc_s;
  assign fifo_unused_s = ^{full_s, level_s};

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_we_o    = 1'b0;
  assign wb_addr_o  = wb_addr_q;
  assign rd_valid_o = ~empty_s;

  sync_fifo_fwft #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_s),
    .din_i      (wb_dat_i),
    .pop_i      (pop_s),
    .dout_o     (rd_data_o),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .one_free_o (one_free_s),
    .level_o    (level_s)
  );

  // Run sequencing; a start facing a FIFO still full of old bytes waits in HOLD
  // so that an acknowledge can never arrive with nowhere to put the byte.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = {TMO_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i != {LEN_W{1'b0}}) begin
            addr_d  = base_i;
            cnt_d   = len_i;
            state_d = room_s ? ST_REQ : ST_HOLD;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (wb_ack_i) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? ST_FIN : ST_GAP;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d   = tmo_inc_s;
        end
      end
      ST_GAP:  state_d = room_s ? ST_REQ : ST_HOLD;
      ST_HOLD: state_d = room_s ? ST_REQ : ST_HOLD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The bus address follows the fetch pointer only while a cycle is presented.
  always_comb begin
    if (state_d == ST_REQ) begin
      wb_addr_d = addr_d;
    end else begin
      wb_addr_d = wb_addr_q;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wb_addr_q <= {ADDR_W{1'b0}};
      cnt_q     <= {LEN_W{1'b0}};
      tmo_q     <= {TMO_W{1'b0}};
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FIN);
      cyc_q     <= (state_d == ST_REQ);
    end
  end

endmodule
